// File: rtl/block_reduce_4xn_pkg.sv
// ---------------------------------------------------------------------------
// block_reduce_4xn_pkg
// Shared definitions for the tile-reduction engine and the systolic_array_4x4
// bank wrappers:
//   - reduce_state_e : controller states (IDLE, WAIT, REDUCE, DONE)
//   - laneSlot       : position of (row, lane) inside a 16-lane tile vector,
//                      lane 0 being the MSB slice of each 4-lane row word
//   - levelOffset    : bit offset of each adder-tree level inside the flat
//                      tree bus (level 0 is the raw tile input)
// No ports. Configuration macro used by the top level: BLOCK_REDUCE_SAT_EN.
// ---------------------------------------------------------------------------
package block_reduce_4xn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } reduce_state_e;

    localparam int LANES_PER_ROW  = 4;
    localparam int ROWS_PER_TILE  = 4;
    localparam int LANES_PER_TILE = LANES_PER_ROW * ROWS_PER_TILE;

    // Lane 0 sits in the most significant slice of its row word, so the slot
    // index counts lanes from the right.
    function automatic int laneSlot(input int row, input int lane);
        return row * LANES_PER_ROW + (LANES_PER_ROW - 1 - lane);
    endfunction

    // Level j of the tree holds (nTiles*16 >> j) lanes of (bw + j) bits; the
    // levels are stacked back to back starting with the raw tile input.
    function automatic int levelOffset(input int nTiles, input int bw, input int level);
        int off;
        off = 0;
        for (int j = 0; j < level; j++) begin
            off += ((nTiles * LANES_PER_TILE) >> j) * (bw + j);
        end
        return off;
    endfunction

endpackage

// File: rtl/block_reduce_4xn_tree_add_level.sv
// ---------------------------------------------------------------------------
// tree_add_level
// One registered level of the lane-wise adder tree. Lane i of the output is
// the sign-extended sum of input lanes i and i+PAIRS, so the upper half of the
// input vector folds onto the lower half.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low clear of the level register
//   en_i    in  load enable for the level register
//   data_i  in  2*PAIRS lanes of IN_W bits, lane i at [i*IN_W +: IN_W]
//   sum_o   out PAIRS lanes of IN_W+1 bits, registered
// ---------------------------------------------------------------------------
module tree_add_level
    import block_reduce_4xn_pkg::*;
#(
    parameter int PAIRS = 8,
    parameter int IN_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic [2*PAIRS*IN_W-1:0]     data_i,
    output logic [PAIRS*(IN_W+1)-1:0]   sum_o
);

    localparam int OUT_W = IN_W + 1;

    logic [PAIRS*OUT_W-1:0] sum_d;
    logic [PAIRS*OUT_W-1:0] sum_q;

    // One extra bit per level keeps every pairwise sum exact.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < PAIRS; i++) begin
            sum_d[i*OUT_W +: OUT_W] = OUT_W'($signed(data_i[i*IN_W +: IN_W]))
                                    + OUT_W'($signed(data_i[(i+PAIRS)*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/block_reduce_4xn.sv
// ---------------------------------------------------------------------------
// block_reduce_4xn
// Sums the 4x4 partial-result tiles of N_TILES systolic arrays lane-wise into
// one 4x4 block through a registered adder tree, with a start/busy/done
// handshake, a programmable compute window and optional accumulation onto the
// previous result.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   start      in  launch request, honoured only in IDLE
//   acc_en     in  sampled with start; adds the new sum to the current row_out
//   tile_rows  in  N_TILES tiles of 16 lanes; word w = t*4+r, lane 0 = MSB slice
//   busy       out high while a reduction is in flight
//   done       out one-cycle pulse when row_out is updated
//   row_out    out 4x4 result block, packed like tile 0
// Configuration: define BLOCK_REDUCE_SAT_EN to clamp each lane to the signed
// BIT_WIDTH range; otherwise the result wraps to its low BIT_WIDTH bits.
// ---------------------------------------------------------------------------
module block_reduce_4xn
    import block_reduce_4xn_pkg::*;
#(
    parameter int BIT_WIDTH      = 16,
    parameter int FRAC_WIDTH     = 8,
    parameter int N_TILES        = 8,
    parameter int COMPUTE_CYCLES = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   acc_en,
    input  logic [N_TILES*LANES_PER_TILE*BIT_WIDTH-1:0] tile_rows,
    output logic                                   busy,
    output logic                                   done,
    output logic [LANES_PER_TILE*BIT_WIDTH-1:0]    row_out
);

    localparam int LOG2N     = $clog2(N_TILES);
    localparam int TW        = BIT_WIDTH + LOG2N;
    localparam int SW        = TW + 1;
    localparam int CNT_W     = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam int STG_W     = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int TILE_BITS = levelOffset(N_TILES, BIT_WIDTH, 1);
    localparam int TOP_OFF   = levelOffset(N_TILES, BIT_WIDTH, LOG2N);
    localparam int TREE_BITS = levelOffset(N_TILES, BIT_WIDTH, LOG2N + 1);

    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (BIT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

    // Fixed-point scaling is the same on every input, so FRAC_WIDTH only
    // needs to be consistent with the lane width.
    if (N_TILES < 2 || (1 << LOG2N) != N_TILES) begin : g_bad_ntiles
        $error("N_TILES must be a power of two and at least 2");
    end
    if (COMPUTE_CYCLES < 1) begin : g_bad_cycles
        $error("COMPUTE_CYCLES must be at least 1");
    end
    if (FRAC_WIDTH >= BIT_WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be smaller than BIT_WIDTH");
    end

    reduce_state_e                         state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [STG_W-1:0]                      stage_q, stage_d;
    logic                                  acc_q, acc_d;
    logic [LANES_PER_TILE*BIT_WIDTH-1:0]   rowOut_q;
    logic [LANES_PER_TILE*BIT_WIDTH-1:0]   rowNext;
    logic                                  capture;
    logic                                  loadOut;
    logic [TREE_BITS-1:0]                  treeBus;
    logic [LANES_PER_TILE*TW-1:0]          treeOut;

    // Controller: a launch waits out the compute window, captures the tiles
    // into level 1, lets the remaining levels settle one per cycle, then
    // writes the result and pulses done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        acc_d   = acc_q;
        capture = 1'b0;
        loadOut = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    acc_d   = acc_en;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(COMPUTE_CYCLES - 1)) begin
                    capture = 1'b1;
                    stage_d = '0;
                    state_d = ST_REDUCE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REDUCE: begin
                if (stage_q == STG_W'(LOG2N - 1)) begin
                    loadOut = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    stage_d = stage_q + STG_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            stage_q  <= '0;
            acc_q    <= 1'b0;
            rowOut_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            acc_q   <= acc_d;
            if (loadOut) begin
                rowOut_q <= rowNext;
            end
        end
    end

    // The tree bus stacks the raw tiles and every level output back to back.
    // Level 1 loads only on the capture edge, so later tile changes are
    // ignored; deeper levels free-run on the held level-1 values.
    assign treeBus[TILE_BITS-1:0] = tile_rows;

    for (genvar k = 1; k <= LOG2N; k++) begin : g_level
        localparam int IN_W    = BIT_WIDTH + k - 1;
        localparam int PAIRS   = (N_TILES * LANES_PER_TILE) >> k;
        localparam int IN_OFF  = levelOffset(N_TILES, BIT_WIDTH, k - 1);
        localparam int OUT_OFF = levelOffset(N_TILES, BIT_WIDTH, k);

        tree_add_level #(
            .PAIRS (PAIRS),
            .IN_W  (IN_W)
        ) u_level (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   ((k == 1) ? capture : 1'b1),
            .data_i (treeBus[IN_OFF +: 2*PAIRS*IN_W]),
            .sum_o  (treeBus[OUT_OFF +: PAIRS*(IN_W+1)])
        );
    end

    assign treeOut = treeBus[TOP_OFF +: LANES_PER_TILE*TW];

    function automatic logic [BIT_WIDTH-1:0] narrowLane(input logic signed [SW-1:0] s);
`ifdef BLOCK_REDUCE_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[BIT_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[BIT_WIDTH-1:0];
        end
        return s[BIT_WIDTH-1:0];
`else
        return s[BIT_WIDTH-1:0];
`endif
    endfunction

    // Final lane value: tree result plus, when accumulating, the previous
    // result, both sign-extended to SW before narrowing back to BIT_WIDTH.
    always_comb begin
        logic signed [SW-1:0] laneSum;
        laneSum = '0;
        rowNext = '0;
        for (int r = 0; r < ROWS_PER_TILE; r++) begin
            for (int l = 0; l < LANES_PER_ROW; l++) begin
                laneSum = SW'($signed(treeOut[laneSlot(r, l)*TW +: TW]))
                        + (acc_q ? SW'($signed(rowOut_q[laneSlot(r, l)*BIT_WIDTH +: BIT_WIDTH]))
                                 : SW'(0));
                rowNext[laneSlot(r, l)*BIT_WIDTH +: BIT_WIDTH] = narrowLane(laneSum);
            end
        end
    end

    assign busy    = (state_q == ST_WAIT) || (state_q == ST_REDUCE);
    assign done    = (state_q == ST_DONE);
    assign row_out = rowOut_q;

endmodule

// File: tb/tb_block_reduce_4xn.sv
// ---------------------------------------------------------------------------
// tb_block_reduce_4xn
// Directed bench for block_reduce_4xn at default parameters. Each launch is
// driven by applyStimulus, which measures the start-to-done latency, watches
// busy and done, and optionally disturbs the inputs mid-flight; results are
// compared against hand-computed blocks by checkOutput. Honours
// BLOCK_REDUCE_SAT_EN for the overflow expectations.
// ---------------------------------------------------------------------------
module tb_block_reduce_4xn;

    localparam int BW    = 16;
    localparam int NT    = 8;
    localparam int LAT   = 19;
    localparam int CAPK  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              acc_en;
    logic [NT*16*BW-1:0] tile_rows;
    logic              busy;
    logic              done;
    logic [16*BW-1:0]  row_out;

    int assertCount = 0;
    int failCount   = 0;

    block_reduce_4xn #(
        .BIT_WIDTH      (BW),
        .FRAC_WIDTH     (8),
        .N_TILES        (NT),
        .COMPUTE_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_en    (acc_en),
        .tile_rows (tile_rows),
        .busy      (busy),
        .done      (done),
        .row_out   (row_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate assertion per comparison; a miss is counted and reported.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fillAll(input logic [15:0] value);
        tile_rows = {(NT*16){value}};
    endtask

    task automatic setLane(input int t, input int r, input int l, input logic [15:0] value);
        tile_rows[(((t*4 + r)*4) + 3 - l)*BW +: BW] = value;
    endtask

    task automatic scrambleTiles();
        for (int i = 0; i < (NT*16*BW)/32; i++) begin
            tile_rows[i*32 +: 32] = $urandom();
        end
    endtask

    // Launches one reduction and follows it to completion and beyond.
    task automatic applyStimulus(input string tag, input logic accIn,
                                 input bit scramble, input bit extraStarts);
        int latency;
        int extraDone;
        logic busyAll;
        latency   = 0;
        extraDone = 0;
        acc_en = accIn;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        acc_en = 1'b0;
        busyAll = busy;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                latency = k;
                break;
            end
            if (!busy) busyAll = 1'b0;
            if (scramble && k >= CAPK) scrambleTiles();
            if (extraStarts) start = (k == 5 || k == 17);
        end
        start = 1'b0;
        checkOutput({tag, ".latency"}, 256'(latency), 256'(LAT));
        checkOutput({tag, ".busyInFlight"}, 256'(busyAll), 256'(1));
        checkOutput({tag, ".busyAtDone"}, 256'(busy), 256'(0));
        @(posedge clk); #1;
        checkOutput({tag, ".doneFalls"}, 256'(done), 256'(0));
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) extraDone++;
        end
        checkOutput({tag, ".noRelaunch"}, 256'(extraDone), 256'(0));
    endtask

    logic [255:0] expRow;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        acc_en    = 1'b0;
        tile_rows = '0;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("reset.busy", 256'(busy), 256'(0));
        checkOutput("reset.done", 256'(done), 256'(0));
        checkOutput("reset.row_out", row_out, 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] uniform 0x0100, no accumulation");
        fillAll(16'h0100);
        applyStimulus("uni", 1'b0, 1'b0, 1'b0);
        checkOutput("uni.row_out", row_out, {16{16'h0800}});

        $display("[TB] uniform 0x0100, accumulate");
        applyStimulus("acc", 1'b1, 1'b0, 1'b0);
        checkOutput("acc.row_out", row_out, {16{16'h1000}});

        $display("[TB] positive overflow");
        fillAll(16'h7000);
        applyStimulus("posOvf", 1'b0, 1'b0, 1'b0);
`ifdef BLOCK_REDUCE_SAT_EN
        checkOutput("posOvf.row_out", row_out, {16{16'h7FFF}});
`else
        checkOutput("posOvf.row_out", row_out, {16{16'h8000}});
`endif

        $display("[TB] negative overflow");
        fillAll(16'h9000);
        applyStimulus("negOvf", 1'b0, 1'b0, 1'b0);
        checkOutput("negOvf.row_out", row_out, {16{16'h8000}});

        $display("[TB] mixed pattern, inputs scrambled after capture");
        for (int t = 0; t < NT; t++) begin
            for (int r = 0; r < 4; r++) begin
                for (int l = 0; l < 4; l++) begin
                    setLane(t, r, l, (t % 2 == 0) ? 16'h0100 : 16'hFF00);
                end
            end
        end
        expRow = '0;
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 4; l++) begin
                setLane(0, r, l, 16'(r*4 + l));
                expRow[((r*4) + 3 - l)*BW +: BW] = 16'(r*4 + l - 256);
            end
        end
        applyStimulus("pattern", 1'b0, 1'b1, 1'b0);
        checkOutput("pattern.row_out", row_out, expRow);

        $display("[TB] start pulses while busy");
        fillAll(16'h0100);
        applyStimulus("ignore", 1'b0, 1'b0, 1'b1);
        checkOutput("ignore.row_out", row_out, {16{16'h0800}});

        $display("[TB] reset mid-WAIT");
        fillAll(16'h0300);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midRst.busyBefore", 256'(busy), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.busy", 256'(busy), 256'(0));
        checkOutput("midRst.done", 256'(done), 256'(0));
        checkOutput("midRst.row_out", row_out, 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fillAll(16'h0100);
        applyStimulus("afterRst", 1'b1, 1'b0, 1'b0);
        checkOutput("afterRst.row_out", row_out, {16{16'h0800}});

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/block_reduce_4xn.md
# block_reduce_4xn

Parametrised tile-reduction engine for block-based matrix multiplication: sums the 4x4 partial-result tiles of N_TILES systolic arrays lane-wise into one 4x4 result block through a pipelined adder tree. Sits between the bank of systolic_array_4x4 tiles and the result write-back. Adds a start/busy/done handshake, programmable compute window, K-block accumulation and saturation over the fixed 8-tile block.

## Interface
- BIT_WIDTH, 16, lane width, signed two's complement fixed point
- FRAC_WIDTH, 8, fractional bits; documentary only, since addition needs no rescale
- N_TILES, 8, tiles reduced; power of two, >= 2
- COMPUTE_CYCLES, 16, cycles from start to tile-output capture, covering systolic fill/drain; >= 1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  launch request; sampled only in IDLE
- acc_en  in  1  sampled with start; 1 adds the new result to the current row_out
- tile_rows  in  N_TILES*16*BIT_WIDTH  tile outputs; row word w = t*4+r occupies bits [(w+1)*4*BIT_WIDTH-1 : w*4*BIT_WIDTH]; lane 0 is the MSB slice of each word
- busy  out  1  high from the edge after an accepted start until done
- done  out  1  one-cycle pulse; row_out valid from this cycle on
- row_out  out  16*BIT_WIDTH  result rows 0..3, same word and lane packing as tile 0

## Operation
- LOG2N = log2(N_TILES). Internal sum width SW = BIT_WIDTH + LOG2N + 1.
- FSM states:
  - IDLE: start=1 goes to WAIT; cnt cleared; acc_en latched into acc_q.
  - WAIT: cnt increments each cycle. When cnt = COMPUTE_CYCLES-1, the next edge captures the first tree level and enters REDUCE.
  - REDUCE: a stage counter runs LOG2N-1 cycles, then the next edge loads row_out and enters DONE.
  - DONE: done=1 for one cycle, then the next edge returns to IDLE.
- Tree, level 1: pairwise sign-extended sums of tile t and tile t+N_TILES/2, per row and lane. Each further level halves the count. Every level is registered.
- Final value per lane: S = tree_out + (acc_q ? sign_ext(row_out_lane) : 0), then narrowed to BIT_WIDTH.
- tile_rows is read only at the level-1 capture edge; later changes have no effect.
- start while busy or in DONE is ignored; it is not queued.
- Reset asserted in any state: state goes to IDLE, and busy, done, row_out, counters and tree registers all go to 0 immediately.
- Reset values: busy=0, done=0, row_out=0.

## Timing
- Edge E0 samples start in IDLE. The level-1 capture occurs at edge E(COMPUTE_CYCLES). row_out is loaded and done rises at E(COMPUTE_CYCLES+LOG2N). done falls at the next edge.
- busy is 1 from E0 until done rises; busy and done are never both high.
- Back-to-back operation: start may be asserted in the cycle done is high. It is sampled at the edge returning to IDLE? No: it is sampled only in IDLE, so the earliest new launch is one cycle after done.
- Default parameters give done 19 cycles after E0.

## Configuration
- BLOCK_REDUCE_SAT_EN defined: S is clamped to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1] per lane.
- BLOCK_REDUCE_SAT_EN undefined: S is truncated to its low BIT_WIDTH bits (wrap-around).
- The macro has no effect on tree width or latency.

## Structure
- Shared package: FSM state encoding (IDLE, WAIT, REDUCE, DONE) and the lane pack/unpack index helpers, common to the systolic_array_4x4 bank wrappers.
- One sub-module: tree_add_level. It is parametrised by pair count and input width, and implements one registered lane-wise level, with an asynchronous clear driven by rst_n. It is instantiated LOG2N times in a generate loop.

## Test plan
All cases use default parameters unless stated.
- All lanes of all tiles = 0x0100, acc_en=0, start -> done exactly 19 cycles after E0; every row_out lane = 0x0800; busy high for cycles 1..18.
- Repeat the previous case with acc_en=1 -> every lane = 0x1000.
- All lanes = 0x7000 -> every lane = 0x7FFF with BLOCK_REDUCE_SAT_EN defined, 0x8000 without. All lanes = 0x9000 -> 0x8000 with saturation, 0x8000 without (wrapped value).
- Even tiles 0x0100 and odd tiles 0xFF00, with row r lane l of tile 0 overwritten to r*4+l -> lane value = (r*4+l) - 0x0100 in 16-bit two's complement. tile_rows randomised from the capture edge onward -> result unchanged.
- start pulsed during WAIT and REDUCE -> ignored; exactly one done pulse.
- rst_n low mid-WAIT -> busy, done and row_out are 0 without waiting for a clock edge. A fresh start after release -> full 19-cycle latency and correct sum.
